// File: rtl/wb_grf.sv
// Write-back stage and 32x32 general register file with write-through read ports and retire counter.
// Define GRF_TRACE_EN to print one line for every committed register write.
module wb_grf #(
    parameter int LINK_OFFSET = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      wb_pc,
    input  logic [31:0]      wb_instr,
    input  logic [31:0]      wb_alu,
    input  logic [31:0]      wb_hilo,
    input  logic [31:0]      wb_dm,
    input  logic [31:0]      wb_shift,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic             wb_we,
    output logic [4:0]       wb_waddr,
    output logic [31:0]      wb_wdata,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] link;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        dec_we;
    logic [4:0]  dec_waddr;
    logic [31:0] dec_wdata;
    logic        wr_en;

    logic [31:0]      grf_q [32];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign op       = wb_instr[31:26];
    assign funct    = wb_instr[5:0];
    assign rt       = wb_instr[20:16];
    assign rd       = wb_instr[15:11];
    assign link     = wb_pc + 32'(LINK_OFFSET);
    assign half_sel = wb_alu[1] ? wb_dm[31:16] : wb_dm[15:0];

    always_comb begin
        byte_sel = wb_dm[7:0];
        case (wb_alu[1:0])
            2'd1:    byte_sel = wb_dm[15:8];
            2'd2:    byte_sel = wb_dm[23:16];
            2'd3:    byte_sel = wb_dm[31:24];
            default: byte_sel = wb_dm[7:0];
        endcase
    end

    always_comb begin
        dec_we    = 1'b0;
        dec_waddr = 5'd0;
        dec_wdata = 32'd0;
        case (op)
            OP_RTYPE: begin
                dec_waddr = rd;
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU: begin
                        dec_we    = 1'b1;
                        dec_wdata = wb_alu;
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        dec_we    = 1'b1;
                        dec_wdata = wb_shift;
                    end
                    FN_MFHI, FN_MFLO: begin
                        dec_we    = 1'b1;
                        dec_wdata = wb_hilo;
                    end
                    FN_JALR: begin
                        dec_we    = 1'b1;
                        dec_wdata = link;
                    end
                    default: dec_we = 1'b0;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                dec_we    = 1'b1;
                dec_waddr = rt;
                dec_wdata = wb_alu;
            end
            OP_LW: begin
                dec_we    = 1'b1;
                dec_waddr = rt;
                dec_wdata = wb_dm;
            end
            OP_LB, OP_LBU: begin
                dec_we    = 1'b1;
                dec_waddr = rt;
                dec_wdata = {{24{byte_sel[7] & (op == OP_LB)}}, byte_sel};
            end
            OP_LH, OP_LHU: begin
                dec_we    = 1'b1;
                dec_waddr = rt;
                dec_wdata = {{16{half_sel[15] & (op == OP_LH)}}, half_sel};
            end
            OP_JAL: begin
                dec_we    = 1'b1;
                dec_waddr = 5'd31;
                dec_wdata = link;
            end
            default: dec_we = 1'b0;
        endcase
    end

    // A zero instruction word decodes as sll $0 but is a bubble; $0 is never a real target.
    assign wr_en    = dec_we && (wb_instr != 32'd0) && (dec_waddr != 5'd0);
    assign wb_we    = wr_en;
    assign wb_waddr = wr_en ? dec_waddr : 5'd0;
    assign wb_wdata = wr_en ? dec_wdata : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                grf_q[i] <= 32'd0;
            end
        end else if (wr_en) begin
            grf_q[dec_waddr] <= dec_wdata;
`ifdef GRF_TRACE_EN
            $display("@%08h: $%02d <= %08h", wb_pc, dec_waddr, dec_wdata);
`endif
        end
    end

    assign cnt_d = (wb_instr != 32'd0) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;

    // Reads go to zero as soon as reset rises, so a coincident write is not bypassed either.
    assign rs_data = (reset || rs_addr == 5'd0) ? 32'd0 :
                     (wr_en && rs_addr == dec_waddr) ? dec_wdata : grf_q[rs_addr];
    assign rt_data = (reset || rt_addr == 5'd0) ? 32'd0 :
                     (wr_en && rt_addr == dec_waddr) ? dec_wdata : grf_q[rt_addr];

endmodule

// File: tb/tb_wb_grf.sv
// Bench for wb_grf: directed instruction vectors, a reference register-file model checked every cycle,
// and literal expectations for the key cases.
module tb_wb_grf;

    logic        clk;
    logic        reset;
    logic [31:0] wb_pc;
    logic [31:0] wb_instr;
    logic [31:0] wb_alu;
    logic [31:0] wb_hilo;
    logic [31:0] wb_dm;
    logic [31:0] wb_shift;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_grf [32];
    logic [31:0] m_cnt;

    wb_grf #(.LINK_OFFSET(8), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_pc     (wb_pc),
        .wb_instr  (wb_instr),
        .wb_alu    (wb_alu),
        .wb_hilo   (wb_hilo),
        .wb_dm     (wb_dm),
        .wb_shift  (wb_shift),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wb_we     (wb_we),
        .wb_waddr  (wb_waddr),
        .wb_wdata  (wb_wdata),
        .retire_cnt(retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference write-back rules, using numeric opcode values.
    function automatic void model_wb(input logic [31:0] instr, input logic [31:0] pc,
                                     input logic [31:0] alu, input logic [31:0] hilo,
                                     input logic [31:0] dm, input logic [31:0] sh,
                                     output logic we, output logic [4:0] wa,
                                     output logic [31:0] wd);
        int opv;
        int fnv;
        logic [31:0] v;
        opv = int'(instr[31:26]);
        fnv = int'(instr[5:0]);
        we = 1'b0;
        wa = 5'd0;
        wd = 32'd0;
        if (instr != 32'd0) begin
            if (opv == 0) begin
                wa = instr[15:11];
                we = 1'b1;
                if (fnv inside {33, 35, 36, 37, 42, 43}) wd = alu;
                else if (fnv inside {0, 2, 3}) wd = sh;
                else if (fnv inside {16, 18}) wd = hilo;
                else if (fnv == 9) wd = pc + 32'd8;
                else we = 1'b0;
            end else if (opv == 3) begin
                we = 1'b1;
                wa = 5'd31;
                wd = pc + 32'd8;
            end else begin
                wa = instr[20:16];
                we = 1'b1;
                if (opv inside {9, 10, 12, 13, 15}) wd = alu;
                else if (opv == 35) wd = dm;
                else if (opv == 32 || opv == 36) begin
                    v = (dm >> (8 * int'(alu[1:0]))) % 256;
                    if (opv == 32 && v >= 128) v = v - 32'd256;
                    wd = v;
                end else if (opv == 33 || opv == 37) begin
                    v = (dm >> (16 * int'(alu[1]))) % 65536;
                    if (opv == 33 && v >= 32768) v = v - 32'd65536;
                    wd = v;
                end else we = 1'b0;
            end
        end
        if (wa == 5'd0) we = 1'b0;
        if (!we) begin
            wa = 5'd0;
            wd = 32'd0;
        end
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (reset || a == 5'd0) return 32'd0;
        if (we && a == wa) return wd;
        return m_grf[a];
    endfunction

    always @(posedge clk or posedge reset) begin
        logic ew;
        logic [4:0] ewa;
        logic [31:0] ewd;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
            m_cnt = 32'd0;
        end else begin
            model_wb(wb_instr, wb_pc, wb_alu, wb_hilo, wb_dm, wb_shift, ew, ewa, ewd);
            if (ew) m_grf[ewa] = ewd;
            if (wb_instr != 32'd0) m_cnt = m_cnt + 32'd1;
        end
    end

    always @(negedge clk) begin
        logic ew;
        logic [4:0] ewa;
        logic [31:0] ewd;
        model_wb(wb_instr, wb_pc, wb_alu, wb_hilo, wb_dm, wb_shift, ew, ewa, ewd);
        check("cyc_we", 32'(wb_we), 32'(ew));
        check("cyc_waddr", 32'(wb_waddr), 32'(ewa));
        check("cyc_wdata", wb_wdata, ewd);
        check("cyc_rs", rs_data, model_rd(rs_addr, ew, ewa, ewd));
        check("cyc_rt", rt_data, model_rd(rt_addr, ew, ewa, ewd));
        check("cyc_cnt", retire_cnt, m_cnt);
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [4:0] rs, input logic [4:0] rt);
        @(posedge clk);
        #1;
        wb_instr = instr;
        wb_pc    = pc;
        wb_alu   = alu;
        wb_dm    = dm;
        rs_addr  = rs;
        rt_addr  = rt;
        #2;
    endtask

    initial begin
        logic [31:0] cnt_snap;
        reset    = 1'b1;
        wb_pc    = 32'd0;
        wb_instr = 32'd0;
        wb_alu   = 32'd0;
        wb_hilo  = 32'h0000_0C0C;
        wb_dm    = 32'd0;
        wb_shift = 32'h0000_ABCD;
        rs_addr  = 5'd0;
        rt_addr  = 5'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            check("reset_rs", rs_data, 32'd0);
            check("reset_rt", rt_data, 32'd0);
        end
        check("reset_cnt", retire_cnt, 32'd0);

        // ori $5
        drive(32'h3405_1234, 32'h0000_1000, 32'h0000_1234, 32'd0, 5'd0, 5'd0);
        check("ori_we", 32'(wb_we), 32'd1);
        check("ori_waddr", 32'(wb_waddr), 32'd5);
        check("ori_wdata", wb_wdata, 32'h0000_1234);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd5);
        check("ori_read", rs_data, 32'h0000_1234);
        check("same_addr", rt_data, rs_data);
        check("ori_cnt", retire_cnt, 32'd1);

        // jal bypass before the edge
        drive(32'h0C00_0000, 32'h0000_3000, 32'd0, 32'd0, 5'd0, 5'd31);
        check("jal_bypass", rt_data, 32'h0000_3008);
        check("jal_waddr", 32'(wb_waddr), 32'd31);

        // Load extension
        drive(32'h8006_0002, 32'h0000_3004, 32'h0000_0002, 32'h80FF_7F01, 5'd0, 5'd0);
        check("lb", wb_wdata, 32'hFFFF_FFFF);
        drive(32'h9007_0002, 32'h0000_3008, 32'h0000_0002, 32'h80FF_7F01, 5'd6, 5'd0);
        check("lbu", wb_wdata, 32'h0000_00FF);
        check("lb_read", rs_data, 32'hFFFF_FFFF);
        drive(32'h8408_0002, 32'h0000_300C, 32'h0000_0002, 32'h80FF_7F01, 5'd0, 5'd0);
        check("lh", wb_wdata, 32'hFFFF_80FF);
        drive(32'h9409_0002, 32'h0000_3010, 32'h0000_0002, 32'h80FF_7F01, 5'd0, 5'd0);
        check("lhu", wb_wdata, 32'h0000_80FF);
        drive(32'h8C0A_0000, 32'h0000_3014, 32'h0000_0000, 32'h80FF_7F01, 5'd9, 5'd8);
        check("lw", wb_wdata, 32'h80FF_7F01);
        check("lhu_read", rs_data, 32'h0000_80FF);
        check("lh_read", rt_data, 32'hFFFF_80FF);
        drive(32'h8C0B_0000, 32'h0000_3018, 32'h0000_0001, 32'h1234_5678, 5'd0, 5'd0);
        drive(32'h800C_0001, 32'h0000_301C, 32'h0000_0001, 32'h1234_5678, 5'd0, 5'd0);
        check("lb_pos", wb_wdata, 32'h0000_0056);

        // R-type sources
        drive(32'h0000_2080, 32'h0000_3020, 32'd0, 32'd0, 5'd0, 5'd0);
        check("sll_wdata", wb_wdata, 32'h0000_ABCD);
        drive(32'h0000_5010, 32'h0000_3024, 32'd0, 32'd0, 5'd0, 5'd4);
        check("mfhi_wdata", wb_wdata, 32'h0000_0C0C);
        drive(32'h0000_F809, 32'h0000_4000, 32'd0, 32'd0, 5'd10, 5'd0);
        check("jalr_wdata", wb_wdata, 32'h0000_4008);
        drive(32'h0000_0018, 32'h0000_4004, 32'd0, 32'd0, 5'd0, 5'd0);
        check("mult_we", 32'(wb_we), 32'd0);
        drive(32'h1000_0004, 32'h0000_4008, 32'd0, 32'd0, 5'd0, 5'd0);
        check("beq_we", 32'(wb_we), 32'd0);

        // $0 target, bubble and store accounting
        drive(32'h0000_0021, 32'h0000_5000, 32'hDEAD_BEEF, 32'd0, 5'd0, 5'd0);
        check("zero_we", 32'(wb_we), 32'd0);
        check("zero_wdata", wb_wdata, 32'd0);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        check("zero_read", rs_data, 32'd0);
        cnt_snap = retire_cnt;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        check("bubble_cnt", retire_cnt, cnt_snap);
        drive(32'hAC03_0000, 32'h0000_5004, 32'h0000_0010, 32'd0, 5'd0, 5'd0);
        check("sw_we", 32'(wb_we), 32'd0);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        check("sw_cnt", retire_cnt, cnt_snap + 32'd1);

        // Async reset mid-run
        drive(32'h2403_0055, 32'h0000_6000, 32'h0000_0055, 32'd0, 5'd0, 5'd0);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd3);
        check("r3_before", rs_data, 32'h0000_0055);
        reset = 1'b1;
        #1;
        check("async_rs", rs_data, 32'd0);
        check("async_cnt", retire_cnt, 32'd0);
        // Write held across an edge in reset must be dropped.
        wb_instr = 32'h340C_0077;
        wb_alu   = 32'h0000_0077;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        wb_instr = 32'd0;
        rs_addr  = 5'd12;
        #1;
        check("reset_drop", rs_data, 32'd0);
        check("reset_drop_cnt", retire_cnt, 32'd0);
        drive(32'h340C_0077, 32'h0000_6004, 32'h0000_0077, 32'd0, 5'd0, 5'd0);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 5'd12, 5'd3);
        check("first_write", rs_data, 32'h0000_0077);
        check("r3_cleared", rt_data, 32'd0);
        check("post_cnt", retire_cnt, 32'd1);

        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
